// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank.
// Holds the transfer FSM encoding, the byte-enable to bit-mask expansion
// and the register-index width calculation.
package opb_regbank_pkg;

    // Transfer sequencer states: accept, acknowledge, then one dead cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Expand byte enables to a 32-bit mask. Bit i of be covers bits [8i+7:8i],
    // so be[3] corresponds to the most significant byte lane (OPB_BE[0]).
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

    // Bits needed to index n registers, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/opb_regbank_cell.sv
// One 32-bit software-writable register of the OPB register bank.
// Applies byte-masked writes, produces a one-cycle update strobe after each
// write and, when PULSE is set, falls back to RESET_VAL one cycle after a write.
module opb_regbank_cell #(
    parameter logic [31:0] RESET_VAL = 32'h0,
    parameter bit          PULSE     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] mask,
    output logic [31:0] q,
    output logic        we_pulse
);

    // Set for the single cycle a pulse-mode register shows its written value.
    logic loaded;

    // Register update: a write always wins over the pulse-mode reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= RESET_VAL;
            we_pulse <= 1'b0;
            loaded   <= 1'b0;
        end else begin
            we_pulse <= we;
            if (we) begin
                q      <= (q & ~mask) | (wdata & mask);
                loaded <= PULSE;
            end else begin
                loaded <= 1'b0;
                if (loaded) begin
                    q <= RESET_VAL;
                end
            end
        end
    end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS 32-bit control registers to user logic.
// Each access runs IDLE -> ACK -> GAP; writes commit at the end of ACK.
// Optional feature macro: OPB_REGBANK_ERRACK_EN raises Sl_errAck on accesses to
// unimplemented word offsets inside the window; otherwise Sl_errAck is 0.
// Handshake: a transfer is accepted in IDLE when OPB_select is high and the
// address is inside the window; Sl_xferAck is high for exactly the following
// cycle, Sl_DBus is non-zero only while Sl_xferAck is high, and OPB_select is
// ignored until the FSM is back in IDLE.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01003400,
    parameter logic [31:0] C_HIGHADDR   = 32'h010034FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned C_NUM_REGS   = 8,
    parameter logic [31:0] C_RESET_VAL  = 32'h0,
    parameter logic [63:0] C_PULSE_MASK = 64'h0
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
    input  logic [0:3]                 OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
    input  logic                       OPB_RNW,
    input  logic                       OPB_select,
    input  logic                       OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
    output logic                       Sl_xferAck,
    output logic                       Sl_errAck,
    output logic                       Sl_retry,
    output logic                       Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]   user_data_out,
    output logic [C_NUM_REGS-1:0]      user_we,
    output logic [1:0]                 dbg_state
);

    localparam int unsigned K = idx_width(C_NUM_REGS);

    // Numeric views of the big-endian buses; bit 0 of the bus is the MSB here.
    logic [C_OPB_AWIDTH-1:0] abus_le;
    logic [C_OPB_AWIDTH-1:0] offset;
    logic [C_OPB_AWIDTH-3:0] word;
    logic [31:0]             dbus_le;
    logic [3:0]              be_le;
    logic                    hit;
    logic                    in_range;
    logic [31:0]             rd_word;

    assign abus_le  = OPB_ABus;
    assign dbus_le  = OPB_DBus;
    assign be_le    = OPB_BE;
    assign hit      = OPB_select && (abus_le >= C_BASEADDR) && (abus_le <= C_HIGHADDR);
    assign offset   = abus_le - C_BASEADDR;
    assign word     = offset[C_OPB_AWIDTH-1:2];
    assign in_range = (word < (C_OPB_AWIDTH-2)'(C_NUM_REGS));

    logic [31:0] cell_q [C_NUM_REGS];
    logic [31:0] wr_mask;
    logic        commit;

    // Latched transfer and registered bus outputs.
    state_t      state;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [K-1:0] idx_q;
    logic        rnw_q;
    logic        range_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
`ifdef OPB_REGBANK_ERRACK_EN
    logic        err_q;
`endif

    // Read mux over the implemented registers; unimplemented offsets read 0.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < int'(C_NUM_REGS); r++) begin
            if (word == (C_OPB_AWIDTH-2)'(r)) begin
                rd_word = cell_q[r];
            end
        end
    end

    // Transfer sequencer: accept in IDLE, acknowledge in ACK, rest in GAP.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state   <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            idx_q   <= '0;
            rnw_q   <= 1'b0;
            range_q <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
`ifdef OPB_REGBANK_ERRACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state   <= ST_ACK;
                        ack_q   <= 1'b1;
                        rdata_q <= (OPB_RNW && in_range) ? rd_word : 32'h0;
                        idx_q   <= word[K-1:0];
                        rnw_q   <= OPB_RNW;
                        range_q <= in_range;
                        wdata_q <= dbus_le;
                        be_q    <= be_le;
`ifdef OPB_REGBANK_ERRACK_EN
                        err_q   <= !in_range;
`endif
                    end
                end
                ST_ACK: begin
                    state   <= ST_GAP;
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
`ifdef OPB_REGBANK_ERRACK_EN
                    err_q   <= 1'b0;
`endif
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A write commits on the edge that leaves ACK, only for implemented offsets.
    assign commit  = (state == ST_ACK) && !rnw_q && range_q;
    assign wr_mask = be_to_mask(be_q);

    genvar r;
    generate
        for (r = 0; r < int'(C_NUM_REGS); r++) begin : g_cell
            opb_regbank_cell #(
                .RESET_VAL (C_RESET_VAL),
                .PULSE     (C_PULSE_MASK[r])
            ) u_cell (
                .clk      (OPB_Clk),
                .rst_n    (OPB_Rst_n),
                .we       (commit && (idx_q == K'(r))),
                .wdata    (wdata_q),
                .mask     (wr_mask),
                .q        (cell_q[r]),
                .we_pulse (user_we[r])
            );
            assign user_data_out[32*r +: 32] = cell_q[r];
        end
    endgenerate

    assign Sl_DBus    = rdata_q;
    assign Sl_xferAck = ack_q;
`ifdef OPB_REGBANK_ERRACK_EN
    assign Sl_errAck  = err_q;
`else
    assign Sl_errAck  = 1'b0;
`endif
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign dbg_state  = state;

    // Sequential-address hint and byte offset bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, offset[1:0]};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink with five registers,
// reset value A5A5A5A5 and register 0 in self-clearing mode.
module tb_opb_register_bank_ppc2simulink;

    localparam int          NR   = 5;
    localparam logic [31:0] RV   = 32'hA5A5A5A5;
    localparam logic [63:0] PM   = 64'h1;
    localparam logic [31:0] BASE = 32'h01003400;
    localparam logic [31:0] HIGH = 32'h010034FF;
`ifdef OPB_REGBANK_ERRACK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [0:31]    abus;
    logic [0:3]     be;
    logic [0:31]    dbus;
    logic           rnw;
    logic           sel;
    logic           seq;
    logic [0:31]    sl_dbus;
    logic           xfer_ack;
    logic           err_ack;
    logic           retry;
    logic           tout_sup;
    logic [32*NR-1:0] udo;
    logic [NR-1:0]  uwe;
    logic [1:0]     dbg_state;

    int checks;
    int failures;
    logic [31:0] m_regs [NR];
    logic [31:0] exp_q [$];

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_REGS   (NR),
        .C_RESET_VAL  (RV),
        .C_PULSE_MASK (PM)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel),
        .OPB_seqAddr   (seq),
        .Sl_DBus       (sl_dbus),
        .Sl_xferAck    (xfer_ack),
        .Sl_errAck     (err_ack),
        .Sl_retry      (retry),
        .Sl_toutSup    (tout_sup),
        .user_data_out (udo),
        .user_we       (uwe),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus access starting at a negedge, ending at the negedge after the
    // FSM is back in IDLE. Checks ack, error, read data, register contents
    // and update strobes against the bench's own register model.
    task automatic xfer(input logic [31:0] addr, input logic [3:0] be_b,
                        input logic [31:0] data, input bit rnw_i);
        bit hit;
        bit inr;
        bit exp_err;
        bit pulse_hit;
        bit ok;
        int word;
        logic [31:0] exp_rd;
        logic [31:0] got;
        logic [NR-1:0] exp_we;
        hit  = (addr >= BASE) && (addr <= HIGH);
        word = int'((addr - BASE) >> 2);
        inr  = hit && (word < NR);
        exp_rd = 32'h0;
        if (rnw_i && inr) exp_rd = m_regs[word];
        exp_err = ERR_EN && hit && !inr;
        if (hit) exp_q.push_back(exp_rd);

        abus = addr; be = be_b; dbus = data; rnw = rnw_i; sel = 1'b1;
        @(posedge clk); @(negedge clk);
        sel = 1'b0;
        checks++;
        if (xfer_ack !== hit) begin
            failures++;
            $display("FAIL ack_cycle1 addr=%h: got %0b want %0b", addr, xfer_ack, hit);
        end
        checks++;
        if (err_ack !== exp_err) begin
            failures++;
            $display("FAIL err_ack addr=%h: got %0b want %0b", addr, err_ack, exp_err);
        end
        got = 32'h0;
        if (hit) got = exp_q.pop_front();
        checks++;
        if (sl_dbus !== got) begin
            failures++;
            $display("FAIL rdata addr=%h: got %h want %h", addr, sl_dbus, got);
        end

        exp_we = '0;
        pulse_hit = 1'b0;
        if (inr && !rnw_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) m_regs[word][31-8*i -: 8] = data[31-8*i -: 8];
            end
            exp_we[word] = 1'b1;
            pulse_hit = PM[word];
        end

        @(posedge clk); @(negedge clk);
        checks++;
        if (xfer_ack !== 1'b0 || sl_dbus !== 32'h0 || err_ack !== 1'b0) begin
            failures++;
            $display("FAIL gap_idle_bus addr=%h: ack=%0b err=%0b dbus=%h want 0/0/0",
                     addr, xfer_ack, err_ack, sl_dbus);
        end
        checks++;
        if (uwe !== exp_we) begin
            failures++;
            $display("FAIL user_we addr=%h: got %b want %b", addr, uwe, exp_we);
        end
        ok = 1'b1;
        for (int r = 0; r < NR; r++) if (udo[32*r +: 32] !== m_regs[r]) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL regs_after_commit addr=%h: got %h want %h %h %h %h %h", addr, udo,
                     m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]);
        end
        if (pulse_hit) m_regs[word] = RV;

        @(posedge clk); @(negedge clk);
        checks++;
        if (uwe !== '0) begin
            failures++;
            $display("FAIL user_we_clear addr=%h: got %b want 0", addr, uwe);
        end
        ok = 1'b1;
        for (int r = 0; r < NR; r++) if (udo[32*r +: 32] !== m_regs[r]) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL regs_settled addr=%h: got %h want %h %h %h %h %h", addr, udo,
                     m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]);
        end
    endtask

    task automatic test_reset();
        bit ok;
        abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < NR; r++) m_regs[r] = RV;
        ok = 1'b1;
        for (int r = 0; r < NR; r++) if (udo[32*r +: 32] !== 32'hA5A5A5A5) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_regs: got %h want all A5A5A5A5", udo);
        end
        checks++;
        if (xfer_ack !== 1'b0 || err_ack !== 1'b0 || sl_dbus !== 32'h0 || uwe !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%0b err=%0b dbus=%h we=%b want all 0",
                     xfer_ack, err_ack, sl_dbus, uwe);
        end
        checks++;
        if (retry !== 1'b0 || tout_sup !== 1'b0) begin
            failures++;
            $display("FAIL tied_outputs: retry=%0b tout=%0b want 0", retry, tout_sup);
        end
    endtask

    task automatic test_full_write();
        xfer(32'h01003408, 4'b1111, 32'h12345678, 1'b0);
        checks++;
        if (udo[95:64] !== 32'h12345678) begin
            failures++;
            $display("FAIL full_write_reg2: got %h want 12345678", udo[95:64]);
        end
        xfer(32'h01003408, 4'b1111, 32'h0, 1'b1);
    endtask

    task automatic test_byte_lane();
        xfer(32'h01003408, 4'b0100, 32'hFFFFFFFF, 1'b0);
        checks++;
        if (udo[95:64] !== 32'h12FF5678) begin
            failures++;
            $display("FAIL byte_lane_reg2: got %h want 12FF5678", udo[95:64]);
        end
        xfer(32'h0100340C, 4'b0000, 32'hFFFFFFFF, 1'b0);
    endtask

    task automatic test_pulse();
        xfer(BASE, 4'b1111, 32'h00000001, 1'b0);
        checks++;
        if (udo[31:0] !== RV) begin
            failures++;
            $display("FAIL pulse_reload: got %h want %h", udo[31:0], RV);
        end
    endtask

    task automatic test_out_of_range();
        xfer(32'h01003418, 4'b1111, 32'hDEADBEEF, 1'b0);
        xfer(32'h01003418, 4'b1111, 32'h0, 1'b1);
        xfer(BASE + 32'hFC, 4'b1111, 32'h0, 1'b1);
        xfer(BASE - 32'h4, 4'b1111, 32'h11111111, 1'b0);
        xfer(HIGH + 32'h1, 4'b1111, 32'h22222222, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        int kind;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7) addr = BASE + 32'(4 * $urandom_range(0, NR - 1));
            else if (kind < 9) addr = BASE + 32'(4 * $urandom_range(NR, 63));
            else addr = ($urandom_range(0, 1) == 1) ? BASE - 32'h4 : HIGH + 32'h1;
            xfer(addr, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    // Select held high continuously: one ack every three cycles.
    task automatic test_back_to_back();
        bit exp_ack;
        abus = BASE + 32'h4; be = 4'b1111; dbus = '0; rnw = 1'b1; sel = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); @(negedge clk);
            exp_ack = ((c % 3) == 0);
            checks++;
            if (xfer_ack !== exp_ack) begin
                failures++;
                $display("FAIL b2b_ack c=%0d: got %0b want %0b", c, xfer_ack, exp_ack);
            end
            if (exp_ack) begin
                checks++;
                if (sl_dbus !== m_regs[1]) begin
                    failures++;
                    $display("FAIL b2b_rdata c=%0d: got %h want %h", c, sl_dbus, m_regs[1]);
                end
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_ack();
        bit ok;
        abus = BASE + 32'hC; be = 4'b1111; dbus = $urandom; rnw = 1'b0; sel = 1'b1;
        @(posedge clk); @(negedge clk);
        sel = 1'b0;
        checks++;
        if (xfer_ack !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_ack: got %0b want 1", xfer_ack);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (xfer_ack !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort_ack: got %0b want 0", xfer_ack);
        end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < NR; r++) m_regs[r] = RV;
        @(posedge clk); @(negedge clk);
        ok = 1'b1;
        for (int r = 0; r < NR; r++) if (udo[32*r +: 32] !== RV) ok = 1'b0;
        checks++;
        if (!ok || uwe !== '0) begin
            failures++;
            $display("FAIL rst_no_commit: regs=%h we=%b want all %h / 0", udo, uwe, RV);
        end
        xfer(BASE + 32'hC, 4'b1111, 32'hCAFEF00D, 1'b0);
        xfer(BASE + 32'hC, 4'b1111, 32'h0, 1'b1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_full_write();
        test_byte_lane();
        test_pulse();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
